// File: rtl/nios2_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks: register word
// addresses and the edge-capture selection encodings.
package nios2_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

endpackage

// File: rtl/nios2_system_key_pio_if.sv
// Avalon-MM slave port of the key PIO: register bus plus the interrupt line.
interface nios2_system_key_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios2_system_key_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and debounced flop.
// rise/fall pulse on the very cycle whose clock edge updates deb.
module nios2_system_key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;
  logic             update_s;

  // two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= IDLE_LEVEL;
      sync2_r <= IDLE_LEVEL;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  // deb follows sync2 once it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    update_s = (sync2_r != deb_r) && (cnt_r == CNT_LAST);
    rise     = update_s && sync2_r;
    fall     = update_s && !sync2_r;
  end

  // stability counter and debounced value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
      deb_r <= IDLE_LEVEL;
    end else if (sync2_r == deb_r) begin
      cnt_r <= '0;
    end else if (update_s) begin
      cnt_r <= '0;
      deb_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign deb = deb_r;

endmodule

// File: rtl/nios2_system_key_pio.sv
// Avalon-MM input PIO for push-buttons/switches: debounced data, interrupt
// mask and RW1C edge-capture register driving a level interrupt.
module nios2_system_key_pio
  import nios2_system_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios2_system_key_pio_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port
);

  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [31:0]      rd_mux_s;
  logic [31:0]      readdata_r;
  logic             wr_s;
  // upper write-data bits have no register behind them
  logic [31:0]      writedata_unused_s;

  assign writedata_unused_s = bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios2_system_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .key_in  (in_port[i]),
      .deb     (deb_s[i]),
      .rise    (rise_s[i]),
      .fall    (fall_s[i])
    );
  end

  // select which debounced transitions count as edges
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_s = rise_s;
      EDGE_FALL: edge_s = fall_s;
      EDGE_ANY:  edge_s = rise_s | fall_s;
      default:   edge_s = '0;
    endcase
  end

  // write decode and RW1C clear vector
  always_comb begin
    wr_s = bus.chipselect && !bus.write_n;
    if (wr_s && (bus.address == ADDR_EDGECAP)) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // read mux; unused upper bits stay zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (bus.address)
      ADDR_DATA:    rd_mux_s[WIDTH-1:0] = deb_s;
      ADDR_DIR:     rd_mux_s = 32'd0;
      ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGECAP: rd_mux_s[WIDTH-1:0] = edge_cap_r;
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // mask, sticky capture (new edge beats a same-cycle clear) and read register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_r <= '0;
      edge_cap_r <= '0;
      readdata_r <= 32'd0;
    end else begin
      if (wr_s && (bus.address == ADDR_IRQMASK)) begin
        irq_mask_r <= bus.writedata[WIDTH-1:0];
      end
      edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
      readdata_r <= rd_mux_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = |(edge_cap_r & irq_mask_r);

endmodule
